// File: rtl/nand_cmd_latch.sv
// nand_cmd_latch: NAND CLE/ALE byte latch sequencer with programmable setup/WE#-pulse/hold timing; NAND_CMD_WP_CTRL_EN adds wp_release-driven WP#
module nand_cmd_latch #(
  parameter int DQ_WIDTH = 8,
  parameter int T_SETUP = 2,
  parameter int T_WP = 2,
  parameter int T_HOLD = 2
) (
  input  logic                v_clk0,
  input  logic                v_rst0,
`ifdef NAND_CMD_WP_CTRL_EN
  input  logic                wp_release,
`endif
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_type,
  input  logic [DQ_WIDTH-1:0] req_data,
  input  logic                req_chip,
  input  logic                req_last,
  input  logic                abort,
  output logic                done,
  output logic                v_ctrl_cle,
  output logic                v_ctrl_ale,
  output logic                v_ctrl_wrn,
  output logic                v_ctrl_wpn,
  output logic [1:0]          v_ctrl_cen,
  output logic                v_dq_oe_n,
  output logic [DQ_WIDTH-1:0] v_wr_data_rise,
  output logic [DQ_WIDTH-1:0] v_wr_data_fall
);
  localparam logic [3:0] TS = T_SETUP < 1 ? 4'd1 : 4'(T_SETUP);
  localparam logic [3:0] TW = T_WP < 1 ? 4'd1 : 4'(T_WP);
  localparam logic [3:0] TH = T_HOLD < 1 ? 4'd1 : 4'(T_HOLD);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, PULSE = 2'd2, HOLD = 2'd3;
  logic [1:0] state;
  logic [3:0] cnt;
  logic last;
  logic expired;
  assign expired = cnt == 4'd1;
  always_ff @(posedge v_clk0) begin
    if (v_rst0 || abort) begin
      state <= IDLE;
      cnt <= 4'd0;
      last <= 1'b0;
      req_ready <= !v_rst0;
      done <= 1'b0;
      v_ctrl_cle <= 1'b0;
      v_ctrl_ale <= 1'b0;
      v_ctrl_wrn <= 1'b1;
      v_ctrl_cen <= 2'b11;
      v_dq_oe_n <= 1'b1;
      if (v_rst0) begin
        v_wr_data_rise <= '0;
        v_wr_data_fall <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= !(req_valid && req_ready);
          if (req_valid && req_ready) begin
            state <= SETUP;
            cnt <= TS;
            last <= req_last;
            v_ctrl_cle <= !req_type;
            v_ctrl_ale <= req_type;
            v_ctrl_cen <= req_chip ? 2'b01 : 2'b10;
            v_wr_data_rise <= req_data;
            v_wr_data_fall <= req_data;
            v_dq_oe_n <= 1'b0;
          end
        end
        SETUP: begin
          cnt <= expired ? TW : cnt - 4'd1;
          if (expired) begin
            state <= PULSE;
            v_ctrl_wrn <= 1'b0;
          end
        end
        PULSE: begin
          cnt <= expired ? TH : cnt - 4'd1;
          if (expired) begin
            state <= HOLD;
            v_ctrl_wrn <= 1'b1;
          end
        end
        default: begin
          cnt <= expired ? 4'd0 : cnt - 4'd1;
          if (expired) begin
            state <= IDLE;
            done <= 1'b1;
            req_ready <= 1'b1;
            v_ctrl_cle <= 1'b0;
            v_ctrl_ale <= 1'b0;
            v_dq_oe_n <= 1'b1;
            v_ctrl_cen <= last ? 2'b11 : v_ctrl_cen;
          end
        end
      endcase
    end
  end
`ifdef NAND_CMD_WP_CTRL_EN
  always_ff @(posedge v_clk0) v_ctrl_wpn <= v_rst0 ? 1'b0 : wp_release;
`else
  assign v_ctrl_wpn = 1'b1;
`endif
endmodule

// File: doc/nand_cmd_latch.md
# nand_cmd_latch

Command/address latch sequencer that sits directly upstream of the NAND PHY in the clk0 domain. It accepts one command or address byte per request over a valid/ready handshake and generates the registered `v_ctrl_*` control strobes, the DQ output-enable and the write data the PHY drives onto the bus. Timing uses programmable setup, WE#-pulse and hold cycle counts, so that tCLS/tALS/tWP/tCLH/tALH are met at any clk0 frequency.

## Interface
Parameters:
- `DQ_WIDTH`, 8: data byte width.
- `T_SETUP`, 2: clk0 cycles with CLE/ALE/CE#/DQ stable before WE# falls (1..15).
- `T_WP`, 2: clk0 cycles WE# is held low (1..15).
- `T_HOLD`, 2: clk0 cycles signals are held after WE# rises (1..15).

Ports:
- `v_clk0`, in, 1: clk0; the only clock.
- `v_rst0`, in, 1: reset, synchronous to `v_clk0`, active-high.
- `req_valid`, in, 1: a request is present.
- `req_ready`, out, 1: the block accepts a request this cycle.
- `req_type`, in, 1: 0 = command byte (CLE), 1 = address byte (ALE).
- `req_data`, in, DQ_WIDTH: the byte to latch.
- `req_chip`, in, 1: target chip; selects the `v_ctrl_cen` bit.
- `req_last`, in, 1: release CE# after this byte.
- `abort`, in, 1: return to idle immediately.
- `done`, out, 1: one-cycle pulse when a byte's hold phase completes.
- `v_ctrl_cle`, `v_ctrl_ale`, `v_ctrl_wrn`, `v_ctrl_wpn`, out, 1 each: control strobes to the PHY.
- `v_ctrl_cen`, out, 2: active-low chip enables.
- `v_dq_oe_n`, out, 1: DQ output enable, active-low.
- `v_wr_data_rise`, `v_wr_data_fall`, out, DQ_WIDTH each: write data to the PHY.
- `wp_release`, in, 1: present only with `NAND_CMD_WP_CTRL_EN`.

## Operation
- States are IDLE, SETUP, PULSE and HOLD. One down-counter, 4 bits wide. Parameter values of 0 are clamped to 1.
- All outputs are registered.
- Reset values:
  - cle=0, ale=0, wrn=1, cen=2'b11, dq_oe_n=1, wr_data_rise=wr_data_fall=0.
  - done=0, req_ready=0 while `v_rst0` is high.
  - wpn as defined under Configuration.
- IDLE:
  - `req_ready`=1.
  - On `req_valid & req_ready`, move to SETUP and load counter=T_SETUP.
  - At the same edge: drive cle=~req_type and ale=req_type; set cen[req_chip]=0 and the other bit to 1; set rise=fall=req_data; set dq_oe_n=0.
- SETUP: wrn=1. When the counter expires, go to PULSE with wrn=0 and counter=T_WP.
- PULSE: when the counter expires, go to HOLD with wrn=1 and counter=T_HOLD. The NAND latches on this WE# rising edge.
- HOLD: when the counter expires, go to IDLE and pulse `done`.
  - cle, ale and dq_oe_n return to idle values (0, 0, 1). Data is held, not cleared.
  - If the latched `req_last` is set, cen goes to 2'b11; otherwise cen stays asserted for the next byte.
- Chip switch: a request with a different `req_chip` while CE# is held moves the low bit directly at acceptance. At most one cen bit is low at any time.
- `req_ready` is 0 in SETUP, PULSE and HOLD. Request fields are sampled only at acceptance.
- `abort` (any state, higher priority than acceptance) → next cycle:
  - IDLE with all outputs at their idle/reset values (except wpn and data) and cen=2'b11.
  - No `done` pulse.
- Reset mid-operation behaves like abort, plus data and wpn return to their reset values.

## Timing
- Acceptance at edge e:
  - cle/ale/cen/data are valid from e.
  - wrn=0 from edge e+T_SETUP to edge e+T_SETUP+T_WP.
  - IDLE and `done`=1 at edge e+T_SETUP+T_WP+T_HOLD.
- Earliest next acceptance is at edge e+T_SETUP+T_WP+T_HOLD+1. Byte period is T_SETUP+T_WP+T_HOLD+1 cycles (7 at defaults).
- `done` and `req_ready` are both high in the first IDLE cycle.

## Configuration
- `NAND_CMD_WP_CTRL_EN` defined:
  - The `wp_release` port exists.
  - `v_ctrl_wpn` resets to 0 (write-protected) and is registered from `wp_release` every cycle.
  - `wp_release` is not affected by abort.
- Undefined: no `wp_release` port, and `v_ctrl_wpn` is constant 1.

## Test plan
- After reset, check all outputs at reset values and `req_ready`=0 during reset. After release, `req_ready`=1 and cen=2'b11.
- Command 0x70, chip 0, last=1, default parameters, accepted at e:
  - cle=1, cen=2'b10, dq_oe_n=0 and data 0x70 over [e, e+6).
  - wrn=0 over [e+2, e+4).
  - done at e+6, cen=2'b11 at e+6.
- Command 0x00, then 5 address bytes 0x01..0x05, chip 1, last only on the final byte:
  - cen=2'b01 continuously across bytes.
  - Acceptances 7 cycles apart, ale=1 only for the address bytes.
  - Exactly 6 `done` pulses.
- Chip switch: byte to chip 0 with last=0, then byte to chip 1. cen goes 2'b10 → 2'b01 directly and is never 2'b00.
- Assert `abort` in PULSE. Next cycle: wrn=1, cen=2'b11, dq_oe_n=1, IDLE, no `done`. A following request completes normally.
- With `NAND_CMD_WP_CTRL_EN`:
  - wpn=0 after reset.
  - wp_release=1 gives wpn=1 one cycle later.
  - Rebuild without the macro: wpn=1 always.
